// File: rtl/apu_pkg.sv
// apu_pkg: shared types and default step/delay constants for the APU frame sequencer.
package apu_pkg;
    typedef enum logic {MODE_4STEP, MODE_5STEP} frame_mode_t;
    typedef enum logic {RUN, PEND} fseq_state_t;
    localparam int STEP1_DEF    = 7457;
    localparam int STEP2_DEF    = 14913;
    localparam int STEP3_DEF    = 22371;
    localparam int STEP4_DEF    = 29829;
    localparam int STEP5_DEF    = 37281;
    localparam int DLY_EVEN_DEF = 3;
    localparam int DLY_ODD_DEF  = 4;
endpackage

// File: rtl/frame_write_delay.sv
// frame_write_delay: after a frame register write, counts CPU ticks and flags the tick that resets the sequence.
module frame_write_delay import apu_pkg::*; #(
    parameter int DLY_EVEN = DLY_EVEN_DEF,
    parameter int DLY_ODD  = DLY_ODD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic write,
    input  logic phase,
    output logic reset_now
);
    localparam int DW = $clog2((DLY_EVEN > DLY_ODD ? DLY_EVEN : DLY_ODD) + 1);
    fseq_state_t state, state_nxt;
    logic [DW-1:0] dly, dly_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            dly   <= '0;
        end else begin
            state <= state_nxt;
            dly   <= dly_nxt;
        end
    end
    // A write always (re)starts the delay, even on the tick that would have expired it
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly;
        reset_now = 1'b0;
        if (write) begin
            state_nxt = PEND;
            dly_nxt   = phase ? DW'(DLY_ODD) : DW'(DLY_EVEN);
        end else if (state == PEND && tick) begin
            dly_nxt = dly - DW'(1);
            if (dly == DW'(1)) begin
                reset_now = 1'b1;
                state_nxt = RUN;
            end
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: APU frame counter producing quarter/half-frame pulses and the frame IRQ.
// Define FRAME_SEQ_IRQ_EN to build the frame IRQ flag; otherwise irq is tied low.
module frame_sequencer import apu_pkg::*; #(
    parameter int CNT_W    = 16,
    parameter int STEP1    = STEP1_DEF,
    parameter int STEP2    = STEP2_DEF,
    parameter int STEP3    = STEP3_DEF,
    parameter int STEP4    = STEP4_DEF,
    parameter int STEP5    = STEP5_DEF,
    parameter int DLY_EVEN = DLY_EVEN_DEF,
    parameter int DLY_ODD  = DLY_ODD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_clk_en,
    input  logic       wr_en,
    input  logic       wr_mode,
    input  logic       wr_irq_inhibit,
    input  logic       status_rd,
    output logic       quarter_clk_en,
    output logic       half_clk_en,
    output logic       irq,
    output logic [2:0] step,
    output logic       mode_q
);
    logic [CNT_W-1:0] cnt, nxt;
    logic [2:0] hit_idx;
    logic phase, inhibit, reset_now, wrap, q_hit, h_hit, fire4;
    frame_mode_t mode;
    frame_write_delay #(.DLY_EVEN(DLY_EVEN), .DLY_ODD(DLY_ODD)) u_delay (
        .clk(clk), .rst(rst), .tick(cpu_clk_en), .write(wr_en), .phase(phase), .reset_now(reset_now)
    );
    assign nxt    = cnt + CNT_W'(1);
    assign mode_q = mode;
    // Thresholds are matched against the post-increment count, so step N fires on tick N
    always_comb begin
        hit_idx = nxt == CNT_W'(STEP1) ? 3'd1 :
                  nxt == CNT_W'(STEP2) ? 3'd2 :
                  nxt == CNT_W'(STEP3) ? 3'd3 :
                  nxt == CNT_W'(STEP4) ? 3'd4 :
                  nxt == CNT_W'(STEP5) ? 3'd5 : 3'd0;
        fire4 = mode == MODE_4STEP && hit_idx == 3'd4;
        wrap  = fire4 || (mode == MODE_5STEP && hit_idx == 3'd5);
        q_hit = (hit_idx != 3'd0 && hit_idx <= 3'd3) || wrap;
        h_hit = hit_idx == 3'd2 || wrap;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            phase          <= 1'b0;
            mode           <= MODE_4STEP;
            inhibit        <= 1'b0;
            step           <= 3'd0;
            quarter_clk_en <= 1'b0;
            half_clk_en    <= 1'b0;
        end else begin
            quarter_clk_en <= 1'b0;
            half_clk_en    <= 1'b0;
            if (wr_en) begin
                mode    <= frame_mode_t'(wr_mode);
                inhibit <= wr_irq_inhibit;
            end
            if (cpu_clk_en) begin
                phase <= ~phase;
                if (reset_now) begin
                    cnt            <= '0;
                    step           <= 3'd0;
                    quarter_clk_en <= mode == MODE_5STEP;
                    half_clk_en    <= mode == MODE_5STEP;
                end else begin
                    cnt            <= wrap ? '0 : nxt;
                    quarter_clk_en <= q_hit;
                    half_clk_en    <= h_hit;
                    step           <= wrap ? 3'd0 : q_hit ? hit_idx : step;
                end
            end
        end
    end
`ifdef FRAME_SEQ_IRQ_EN
    logic irq_q, irq_set;
    assign irq_set = cpu_clk_en && !reset_now && fire4 && !inhibit;
    assign irq     = irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_q <= 1'b0;
        else if (irq_set)
            irq_q <= 1'b1;
        else if (status_rd || (wr_en && wr_irq_inhibit))
            irq_q <= 1'b0;
    end
`else
    logic unused_status_rd;
    assign unused_status_rd = status_rd;
    assign irq = 1'b0;
`endif
endmodule
